uart_frame_scheduler: RTL and testbench

Shares the single `Uart` byte transmitter among `NCH` oscilloscope acquisition channels. A round-robin arbiter selects the next ready channel. The block then serialises that channel's sample into a fixed 5-byte frame and hands the bytes one at a time to the UART through its `Data` / `send_en` / `tx_done` handshake. It sits between the per-channel sample capture logic and the UART instance in the top level.

---
 rtl/uart_sched_pkg.sv | 31 +++
 rtl/uart_frame_scheduler_if.sv | 24 ++
 rtl/rr_arbiter.sv | 29 ++
 rtl/uart_frame_scheduler.sv | 157 +++++++++++++++
 tb/tb_uart_frame_scheduler.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_sched_pkg.sv
// Shared types, constants and frame-building helpers for the UART frame scheduler.
package uart_sched_pkg;

    typedef enum logic {StIdle, StWait} state_e;

    localparam int unsigned FRAME_LEN = 5;

    typedef logic [2:0] byte_idx_t;

    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

    function automatic logic [7:0] frame_checksum(input logic [7:0] ch, input logic [7:0] hi,
                                                  input logic [7:0] lo);
        return ch ^ hi ^ lo;
    endfunction

    function automatic logic [7:0] frame_byte(input byte_idx_t idx, input logic [7:0] header,
                                              input logic [7:0] ch, input logic [7:0] hi,
                                              input logic [7:0] lo);
        logic [7:0] b;
        case (idx)
            3'd0:    b = header;
            3'd1:    b = ch;
            3'd2:    b = hi;
            3'd3:    b = lo;
            default: b = frame_checksum(ch, hi, lo);
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_frame_scheduler_if.sv
// Channel request/sample bus plus UART byte handshake seen by the frame scheduler.
interface uart_frame_scheduler_if #(
    parameter int unsigned NCH      = 4,
    parameter int unsigned SAMPLE_W = 12
);
    logic [NCH-1:0]          req;
    logic [NCH*SAMPLE_W-1:0] sample;
    logic [NCH-1:0]          ack;
    logic [7:0]              Data;
    logic                    send_en;
    logic                    tx_done;
    logic                    busy;
    logic                    err;

    modport master (
        input  req, sample, tx_done,
        output ack, Data, send_en, busy, err
    );

    modport slave (
        output req, sample, tx_done,
        input  ack, Data, send_en, busy, err
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request strictly after `last`, wrapping.
module rr_arbiter #(
    parameter int unsigned NCH = 4
) (
    input  logic [NCH-1:0]         req,
    input  logic [$clog2(NCH)-1:0] last,
    output logic [NCH-1:0]         grant,
    output logic [$clog2(NCH)-1:0] idx,
    output logic                   any
);
    localparam int unsigned IW = $clog2(NCH);

    logic [IW-1:0] cand;

    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int unsigned k = 1; k <= NCH; k++) begin
            cand = IW'((32'(last) + k) % NCH);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
        grant = any ? (NCH'(1) << idx) : '0;
    end

endmodule

// File: rtl/uart_frame_scheduler.sv
// Arbitrates NCH sample channels onto one UART and sends each sample as a 5-byte frame
// (header, channel, sample high, sample low, xor checksum) with a per-byte timeout.
module uart_frame_scheduler
    import uart_sched_pkg::*;
#(
    parameter int unsigned NCH      = 4,
    parameter int unsigned SAMPLE_W = 12,
    parameter logic [7:0]  HEADER   = DEFAULT_HEADER,
    parameter int unsigned TIMEOUT  = 65536
) (
    input logic                    Clk,
    input logic                    Reset_n,
    uart_frame_scheduler_if.master bus
);
    localparam int unsigned IW = $clog2(NCH);
    localparam int unsigned CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT - 1);
    localparam byte_idx_t     LAST_IDX = byte_idx_t'(FRAME_LEN - 1);

    state_e                state_q, state_d;
    logic [IW-1:0]         last_q, last_d;
    byte_idx_t             idx_q, idx_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         ch_q, ch_d;
    logic [SAMPLE_W-1:0]   sample_q, sample_d;
    logic [NCH-1:0]        ack_q, ack_d;
    logic [7:0]            data_q, data_d;
    logic                  send_en_q, send_en_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;

    logic [NCH-1:0]        grant;
    logic [IW-1:0]         grant_idx;
    logic                  grant_any;

    logic [15:0]           sample_ext;
    logic [7:0]            ch_byte;

    rr_arbiter #(
        .NCH (NCH)
    ) u_arb (
        .req   (bus.req),
        .last  (last_q),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    // Short samples zero-extend so the high byte naturally pads with zeros.
    assign sample_ext = 16'(sample_q);
    assign ch_byte    = 8'(ch_q);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (grant_any) state_d = StWait;
            StWait: begin
                if (bus.tx_done) begin
                    if (idx_q == LAST_IDX) state_d = StIdle;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        last_d    = last_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        ch_d      = ch_q;
        sample_d  = sample_q;
        ack_d     = '0;
        data_d    = data_q;
        send_en_d = 1'b0;
        busy_d    = busy_q;
        err_d     = err_q;
        unique case (state_q)
            StIdle: begin
                if (grant_any) begin
                    ch_d      = grant_idx;
                    sample_d  = bus.sample[grant_idx*SAMPLE_W +: SAMPLE_W];
                    ack_d     = grant;
                    send_en_d = 1'b1;
                    data_d    = HEADER;
                    busy_d    = 1'b1;
                    idx_d     = '0;
                    cnt_d     = '0;
                end
            end
            StWait: begin
                // A completing byte wins over a simultaneous timeout.
                if (bus.tx_done) begin
                    if (idx_q == LAST_IDX) begin
                        last_d = ch_q;
                        busy_d = 1'b0;
                    end else begin
                        idx_d     = idx_q + 3'd1;
                        send_en_d = 1'b1;
                        data_d    = frame_byte(idx_q + 3'd1, HEADER, ch_byte,
                                               sample_ext[15:8], sample_ext[7:0]);
                        cnt_d     = '0;
                    end
                end else if (cnt_q == CNT_MAX) begin
                    err_d  = 1'b1;
                    last_d = ch_q;
                    busy_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            last_q    <= IW'(NCH - 1);
            idx_q     <= '0;
            cnt_q     <= '0;
            ch_q      <= '0;
            sample_q  <= '0;
            ack_q     <= '0;
            data_q    <= '0;
            send_en_q <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            last_q    <= last_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            ch_q      <= ch_d;
            sample_q  <= sample_d;
            ack_q     <= ack_d;
            data_q    <= data_d;
            send_en_q <= send_en_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    assign bus.ack     = ack_q;
    assign bus.Data    = data_q;
    assign bus.send_en = send_en_q;
    assign bus.busy    = busy_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Bench for uart_frame_scheduler: fixed frame table, timeout/spurious/reset sequences,
// then randomized requests checked against an arithmetic frame and round-robin model.
module tb_uart_frame_scheduler;
    localparam int NCH = 4;
    localparam int SW  = 12;
    localparam int TO  = 100;

    logic Clk     = 1'b0;
    logic Reset_n = 1'b0;

    uart_frame_scheduler_if #(.NCH(NCH), .SAMPLE_W(SW)) bus ();

    uart_frame_scheduler #(
        .NCH      (NCH),
        .SAMPLE_W (SW),
        .HEADER   (8'hA5),
        .TIMEOUT  (TO)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clk = ~Clk;

    int unsigned cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    logic model_done = 1'b0;
    logic spur_done  = 1'b0;
    assign bus.tx_done = model_done | spur_done;

    int          pend      = 0;
    int          byte_no   = 0;
    int          drop_idx  = -1;
    bit          rand_lat  = 1'b0;
    logic        prev_send = 1'b0;
    int unsigned last_done_cyc = 0;
    int unsigned drop_cyc      = 0;
    logic [7:0]  bytes[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // UART model: answers each send_en with tx_done after a latency, optionally drops one byte.
    always @(negedge Clk) begin
        model_done = 1'b0;
        if (!Reset_n) begin
            pend      = 0;
            prev_send = 1'b0;
        end else begin
            if (bus.send_en) begin
                check("send_en spacing", 64'(prev_send), 64'd0);
                check("send_en while uart busy", 64'(pend != 0), 64'd0);
                byte_no = (bus.ack != '0) ? 0 : byte_no + 1;
                bytes.push_back(bus.Data);
                if (byte_no == drop_idx) begin
                    pend     = 0;
                    drop_cyc = cyc;
                end else begin
                    pend = rand_lat ? int'($urandom_range(30, 2)) : 20;
                end
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    model_done    = 1'b1;
                    last_done_cyc = cyc;
                end
            end
            prev_send = bus.send_en;
        end
    end

    function automatic int model_grant(input logic [3:0] rq, input int last);
        for (int k = 1; k <= NCH; k++) begin
            if (rq[(last + k) % NCH]) return (last + k) % NCH;
        end
        return -1;
    endfunction

    function automatic logic [39:0] model_frame(input int g, input int s);
        int b1 = g;
        int b2 = s / 256;
        int b3 = s % 256;
        int b4 = b1 ^ b2 ^ b3;
        return {8'hA5, 8'(b1), 8'(b2), 8'(b3), 8'(b4)};
    endfunction

    task automatic wait_idle(input string tag, input int bound);
        int n = 0;
        while (bus.busy && n < bound) begin
            tick();
            n++;
        end
        check({tag, " frame end"}, 64'(bus.busy), 64'd0);
    endtask

    task automatic run_frame(input string tag, input logic [3:0] rq, input logic [47:0] smp,
                             input logic [3:0] exp_ack, input logic [39:0] exp_fr,
                             input bit hold, input bit chk_b2b);
        bytes.delete();
        bus.req    = rq;
        bus.sample = smp;
        tick();
        check({tag, " ack"}, 64'(bus.ack), 64'(exp_ack));
        check({tag, " first send_en"}, 64'(bus.send_en), 64'd1);
        check({tag, " busy"}, 64'(bus.busy), 64'd1);
        if (chk_b2b) check({tag, " back-to-back gap"}, 64'(cyc - last_done_cyc), 64'd2);
        if (!hold) bus.req = '0;
        wait_idle(tag, 1000);
        check({tag, " byte count"}, 64'(bytes.size()), 64'd5);
        if (bytes.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                check($sformatf("%s byte%0d", tag, i), 64'(bytes[i]),
                      64'(exp_fr[39-8*i -: 8]));
            end
        end
    endtask

    typedef struct {
        logic [3:0]  rq;
        logic [3:0]  exp_ack;
        logic [39:0] exp_fr;
        bit          hold;
        bit          b2b;
    } vec_t;

    localparam logic [47:0] SMP = {12'h800, 12'hABC, 12'hFFF, 12'h123};
    localparam logic [39:0] F0  = 40'hA5_00_01_23_22;
    localparam logic [39:0] F1  = 40'hA5_01_0F_FF_F1;
    localparam logic [39:0] F2  = 40'hA5_02_0A_BC_B4;
    localparam logic [39:0] F3  = 40'hA5_03_08_00_0B;

    vec_t tbl[9];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  rq;
        logic [47:0] smp;
        int          g;
        int          last_m;
        int          n;

        tbl[0] = '{4'b1111, 4'b0001, F0, 1'b1, 1'b0};
        tbl[1] = '{4'b1111, 4'b0010, F1, 1'b1, 1'b1};
        tbl[2] = '{4'b1111, 4'b0100, F2, 1'b1, 1'b1};
        tbl[3] = '{4'b1111, 4'b1000, F3, 1'b1, 1'b1};
        tbl[4] = '{4'b1111, 4'b0001, F0, 1'b1, 1'b1};
        tbl[5] = '{4'b1001, 4'b1000, F3, 1'b0, 1'b1};
        tbl[6] = '{4'b0100, 4'b0100, F2, 1'b0, 1'b1};
        tbl[7] = '{4'b0001, 4'b0001, F0, 1'b0, 1'b1};
        tbl[8] = '{4'b0010, 4'b0010, F1, 1'b0, 1'b1};

        bus.req    = '0;
        bus.sample = '0;
        repeat (3) tick();
        check("reset ack", 64'(bus.ack), 64'd0);
        check("reset Data", 64'(bus.Data), 64'd0);
        check("reset send_en", 64'(bus.send_en), 64'd0);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset err", 64'(bus.err), 64'd0);
        Reset_n = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            run_frame($sformatf("table%0d", i), tbl[i].rq, SMP, tbl[i].exp_ack,
                      tbl[i].exp_fr, tbl[i].hold, tbl[i].b2b);
        end

        // Timeout: byte 2 never completes.
        drop_idx = 2;
        bytes.delete();
        bus.req = 4'b0001;
        tick();
        check("timeout ack", 64'(bus.ack), 64'd1);
        bus.req = '0;
        n = 0;
        while (!bus.err && n < 400) begin
            tick();
            n++;
        end
        check("timeout err", 64'(bus.err), 64'd1);
        check("timeout latency", 64'(cyc - drop_cyc), 64'd100);
        check("timeout busy", 64'(bus.busy), 64'd0);
        check("timeout bytes", 64'(bytes.size()), 64'd3);
        drop_idx = -1;
        run_frame("after timeout", 4'b0100, SMP, 4'b0100, F2, 1'b0, 1'b0);
        check("err sticky", 64'(bus.err), 64'd1);

        // Spurious tx_done while idle.
        tick();
        spur_done = 1'b1;
        tick();
        spur_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("spurious send_en", 64'(bus.send_en), 64'd0);
            check("spurious busy", 64'(bus.busy), 64'd0);
            check("spurious Data hold", 64'(bus.Data), 64'hB4);
        end

        // Reset in the middle of a frame, after byte 2 was issued.
        bytes.delete();
        bus.req    = 4'b0011;
        bus.sample = SMP;
        tick();
        check("midreset ack", 64'(bus.ack), 64'd1);
        bus.req = '0;
        n = 0;
        while (bytes.size() < 3 && n < 200) begin
            tick();
            n++;
        end
        check("midreset reached byte2", 64'(bytes.size()), 64'd3);
        Reset_n = 1'b0;
        #1;
        check("midreset ack", 64'(bus.ack), 64'd0);
        check("midreset Data", 64'(bus.Data), 64'd0);
        check("midreset send_en", 64'(bus.send_en), 64'd0);
        check("midreset busy", 64'(bus.busy), 64'd0);
        check("midreset err", 64'(bus.err), 64'd0);
        tick();
        tick();
        Reset_n = 1'b1;
        tick();
        run_frame("post reset", 4'b1001, SMP, 4'b0001, F0, 1'b0, 1'b0);

        // Randomized requests, samples and UART latency.
        rand_lat = 1'b1;
        last_m   = 0;
        for (int i = 0; i < 40; i++) begin
            rq  = 4'($urandom_range(15, 1));
            smp = 48'({$urandom(), $urandom()});
            g   = model_grant(rq, last_m);
            run_frame($sformatf("rand%0d", i), rq, smp, 4'(1 << g),
                      model_frame(g, int'((smp >> (g * SW)) & 48'hFFF)), 1'b0, 1'b0);
            last_m = g;
            repeat ($urandom_range(2, 0)) tick();
        end
        check("final err clear", 64'(bus.err), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
